hbram_burst_arbiter: RTL
========================

HBRAM_BURST_ARBITER -- requirements
Module: hbram_burst_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, width of every address port.
REQ-002 SHALL have parameter BURST_LEN, default 128, beats per burst; legal range 1..256.
REQ-003 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cal_done  in  1  HBRAM calibration passed; gates new grants.
REQ-006 SHALL have port wr_req  in  1  sensor write-burst request, level.
REQ-007 SHALL have port wr_addr  in  AW  write-burst start address.
REQ-008 SHALL have port wr_gnt  out  1  write burst owns the controller.
REQ-009 SHALL have port wr_done  out  1  one-cycle pulse, write burst complete.
REQ-010 SHALL have port rd_req  in  1  HDMI read-burst request, level.
REQ-011 SHALL have port rd_urgent  in  1  display FIFO below low watermark.
REQ-012 SHALL have port rd_addr  in  AW  read-burst start address.
REQ-013 SHALL have port rd_gnt  out  1  read burst owns the controller.
REQ-014 SHALL have port rd_done  out  1  one-cycle pulse, read burst complete.
REQ-015 SHALL have port cmd_valid  out  1  command to HBRAM controller valid.
REQ-016 SHALL have port cmd_ready  in  1  controller accepts command.
REQ-017 SHALL have port cmd_write  out  1  1 = write, 0 = read.
REQ-018 SHALL have port cmd_addr  out  AW  burst start address.
REQ-019 SHALL have port cmd_len  out  8  BURST_LEN-1, constant.
REQ-020 SHALL have port beat_valid  in  1  one data beat transferred on controller data channel.

Function
REQ-021 SHALL implement FSM states IDLE, CMD, DATA, DONE.
REQ-022 IDLE: arbitrate only when cal_done=1 and (wr_req or rd_req); otherwise stay IDLE, no grant.
REQ-023 Priority: rd_req&rd_urgent -> read; else both requesting -> opposite of last granted direction (last_wr flag, reset 0, so write wins first tie); else the single requester.
REQ-024 On winner selection in cycle N, SHALL capture address and direction and enter CMD with cmd_valid=1 and matching gnt=1 from cycle N+1.
REQ-025 CMD: cmd_valid, cmd_write, cmd_addr held stable until cmd_valid&cmd_ready; then DATA next cycle, cmd_valid=0.
REQ-026 DATA: 9-bit beat counter increments per beat_valid; beat_valid while count=BURST_LEN-1 -> DONE.
REQ-027 DONE: one cycle; wr_done or rd_done=1 per direction, gnt deasserted, last_wr updated, counter cleared; next state IDLE.
REQ-028 Grant SHALL remain 1 continuously from CMD entry through last DATA cycle; at most one of wr_gnt/rd_gnt high ever.
REQ-029 beat_valid outside DATA SHALL be ignored.
REQ-030 Requests and rd_urgent SHALL be sampled only in IDLE; deassertion after grant does not abort the burst.
REQ-031 cal_done falling mid-burst SHALL not abort; no new grant until cal_done=1 again.
REQ-032 Minimum gap between bursts SHALL be DONE+IDLE (2 cycles from last beat to next cmd_valid).
REQ-033 BURST_LEN=1: single beat_valid in DATA SHALL go to DONE.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE, all outputs 0 (cmd_len = BURST_LEN-1 constant), counter 0, last_wr 0, captured address 0.
REQ-035 Reset mid-burst SHALL drop the burst with no done pulse; after rst_n release, first arbitration earliest on next rising edge.

Verification
REQ-036 cal_done=0, wr_req=rd_req=1 for 100 cycles -> no gnt, cmd_valid=0 throughout.
REQ-037 cal_done=1, wr_req only, addr 0x1000, cmd_ready held 0 for 5 cycles -> cmd_valid high with cmd_addr 0x1000, cmd_write=1, cmd_len=127 stable all 6 cycles; 128 beats -> wr_done pulse exactly 1 cycle after the 128th beat.
REQ-038 both requests continuous, rd_urgent=0 -> grants alternate W,R,W,R; next cmd_valid 2 cycles after each done.
REQ-039 both requests, rd_urgent=1 after a read burst -> read granted again, not write.
REQ-040 rst_n pulsed low after 50 of 128 beats -> outputs 0 immediately, no done; after release new burst counts full 128 beats.
REQ-041 beat_valid pulses during CMD and IDLE -> not counted; done arrives only after 128 DATA-state beats.

Source files
------------

// File: rtl/hbram_burst_arbiter.sv
// rtl/hbram_burst_arbiter.sv - arbitrates sensor write and HDMI read bursts onto one HBRAM controller
module hbram_burst_arbiter #(
    parameter int AW        = 32,
    parameter int BURST_LEN = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cal_done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    output logic          wr_gnt,
    output logic          wr_done,
    input  logic          rd_req,
    input  logic          rd_urgent,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_done,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_write,
    output logic [AW-1:0] cmd_addr,
    output logic [7:0]    cmd_len,
    input  logic          beat_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);

    state_t        state_q, state_d;
    logic          dir_wr_q, dir_wr_d;
    logic          last_wr_q, last_wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [8:0]    cnt_q, cnt_d;
    logic          pick_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dir_wr_q  <= 1'b0;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_wr_q  <= dir_wr_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_wr_d  = dir_wr_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        pick_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cal_done && (wr_req || rd_req)) begin
                    // Urgent read beats everything; ties alternate against the last burst.
                    if (rd_req && rd_urgent) begin
                        pick_wr = 1'b0;
                    end else if (wr_req && rd_req) begin
                        pick_wr = !last_wr_q;
                    end else begin
                        pick_wr = wr_req;
                    end
                    dir_wr_d = pick_wr;
                    addr_d   = pick_wr ? wr_addr : rd_addr;
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_DONE: begin
                last_wr_d = dir_wr_q;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic busy;
    assign busy      = (state_q == S_CMD) || (state_q == S_DATA);
    assign wr_gnt    = busy && dir_wr_q;
    assign rd_gnt    = busy && !dir_wr_q;
    assign wr_done   = (state_q == S_DONE) && dir_wr_q;
    assign rd_done   = (state_q == S_DONE) && !dir_wr_q;
    assign cmd_valid = (state_q == S_CMD);
    assign cmd_write = dir_wr_q;
    assign cmd_addr  = addr_q;
    assign cmd_len   = 8'(BURST_LEN - 1);

endmodule
